// File: rtl/aer_bus_arbiter.sv
// Round-robin arbiter that shares one 4-phase AER bus between four spike event sources.
// Optional handshake watchdog compiled in with `define AER_ARB_TIMEOUT_EN.
module aer_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ch1Up_In,
  input  logic       Ch1Down_In,
  input  logic       Ch2Up_In,
  input  logic       Ch2Down_In,
  input  logic       aer_ack,
  output logic       aer_req,
  output logic [1:0] aer_addr,
  output logic       busy,
  output logic       event_drop,
  output logic       timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_e;

  state_e     state_q;
  logic [3:0] ev_raw, ev_s1_q, ev_s2_q, ev_prev_q, ev_edge;
  logic       ack_s1_q, ack_s2_q;
  logic [3:0] pend_q, pend_d, pend_clr;
  logic [1:0] ptr_q, win, rr_idx;
  logic       any_pend, grant;
  logic       req_q, drop_q, drop_d, tout_q;
  logic [1:0] addr_q;
  logic       wd_expire;

  // Index = address: {channel, polarity}.
  assign ev_raw = {Ch2Down_In, Ch2Up_In, Ch1Down_In, Ch1Up_In};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_s1_q   <= '0;
      ev_s2_q   <= '0;
      ev_prev_q <= '0;
      ack_s1_q  <= 1'b0;
      ack_s2_q  <= 1'b0;
    end else begin
      ev_s1_q   <= ev_raw;
      ev_s2_q   <= ev_s1_q;
      ev_prev_q <= ev_s2_q;
      ack_s1_q  <= aer_ack;
      ack_s2_q  <= ack_s1_q;
    end
  end

  assign ev_edge = ev_s2_q & ~ev_prev_q;

  // Walk downward so the source closest to the pointer is the last (winning) assignment.
  always_comb begin
    win      = ptr_q;
    rr_idx   = ptr_q;
    any_pend = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      rr_idx = ptr_q + 2'(i);
      if (pend_q[rr_idx]) begin
        win      = rr_idx;
        any_pend = 1'b1;
      end
    end
  end

  assign grant    = (state_q == S_IDLE) && any_pend && !ack_s2_q;
  assign pend_clr = grant ? (4'b0001 << win) : 4'b0000;
  // A fresh edge on the source being granted re-arms its flag rather than being lost.
  assign pend_d   = (pend_q & ~pend_clr) | ev_edge;
  assign drop_d   = |(ev_edge & pend_q & ~pend_clr);

`ifdef AER_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_q;
  logic             state_chg;

  assign wd_expire = (state_q != S_IDLE) && (wd_q == WD_LAST);
  assign state_chg = ((state_q == S_REQ) && ack_s2_q) ||
                     ((state_q == S_REL) && !ack_s2_q) || wd_expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             wd_q <= '0;
    else if (state_q == S_IDLE || state_chg) wd_q <= '0;
    else                                    wd_q <= wd_q + CNT_W'(1);
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= 2'b00;
      ptr_q   <= 2'b00;
      pend_q  <= '0;
      drop_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_d;
      tout_q <= 1'b0;
      case (state_q)
        S_IDLE: if (grant) begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          addr_q  <= win;
          ptr_q   <= win + 2'd1;
        end
        S_REQ: begin
          if (ack_s2_q) begin
            req_q   <= 1'b0;
            state_q <= S_REL;
          end else if (wd_expire) begin
            req_q   <= 1'b0;
            state_q <= S_IDLE;
            tout_q  <= 1'b1;
          end
        end
        S_REL: begin
          if (!ack_s2_q) begin
            state_q <= S_IDLE;
          end else if (wd_expire) begin
            state_q <= S_IDLE;
            tout_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign aer_req    = req_q;
  assign aer_addr   = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign event_drop = drop_q;
`ifdef AER_ARB_TIMEOUT_EN
  assign timeout_err = tout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/aer_bus_arbiter.md
# aer_bus_arbiter

Shares one 4-phase AER output bus between the two bidirectional spike channels, Ch1 and Ch2. Each channel has separate up and down event lines, giving four event sources. The block captures rising edges on those lines, arbitrates them round-robin and encodes the winner as a 2-bit address. It then runs the req/ack handshake to the downstream receiver. It sits between the AER channel front-end and the off-chip AER link.

## Interface
- TIMEOUT_CYCLES, 255: handshake watchdog limit in clk cycles; only used when the timeout feature is compiled in.
- CNT_W, 8: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Ch1Up_In, Ch1Down_In, Ch2Up_In, Ch2Down_In  in  1 each  asynchronous event lines; a rising edge is one event.
- aer_ack  in  1  asynchronous acknowledge from the receiver.
- aer_req  out  1  bus request, registered.
- aer_addr  out  2  event address {channel, polarity}: Ch1Up=00, Ch1Down=01, Ch2Up=10, Ch2Down=11; registered.
- busy  out  1  high whenever the FSM is not in IDLE.
- event_drop  out  1  one-cycle pulse when an event is lost.
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a handshake.

## Operation
- Each event line and aer_ack pass through a 2-FF synchroniser.
- Each event line also has a third "previous" flop; edge = sync2 & ~prev.
- Four pending flags, one per source:
  - An edge sets the flag.
  - Entering REQ clears the winner's flag.
  - Edge and clear on the same source in the same cycle leaves the flag set, with no drop.
  - An edge on a source whose flag is already set, and not being cleared that cycle, pulses event_drop; the event is lost.
- Round-robin pointer (2 bits) names the source of highest priority. Search order is pointer, pointer+1, ... mod 4. After a grant the pointer becomes winner+1 mod 4.
- FSM states:
  - IDLE: if any flag is set and synced ack = 0, latch the winner into aer_addr, set aer_req=1 and go to REQ. If synced ack = 1, stay in IDLE.
  - REQ: hold aer_req=1 and aer_addr; on synced ack = 1, set aer_req=0 and go to RELEASE.
  - RELEASE: hold aer_addr; on synced ack = 0, go to IDLE.
- aer_addr is stable from the cycle aer_req rises until the FSM returns to IDLE.
- Events arriving during a handshake are queued in the flags, at most one per source.

## Timing
- Reset asserted, at any time including mid-handshake, forces all of the following immediately and asynchronously:
  - aer_req=0, aer_addr=00, busy=0, event_drop=0, timeout_err=0
  - all flags cleared, pointer=0, synchronisers=0, FSM=IDLE, watchdog count=0
- Event latency: input first sampled high at edge k → flag set after edge k+2 → aer_req=1 after edge k+3, provided the FSM is idle and ack is low.
- Ack latency: aer_ack first sampled high at edge m → aer_req=0 after edge m+2. Ack sampled low at edge n → FSM in IDLE after edge n+2; the next aer_req can rise after edge n+3.
- Minimum handshake period: 6 cycles plus external ack delays.
- event_drop and timeout_err are registered and last exactly one cycle.
- Back-to-back events from the same source must be at least 2 cycles apart at the input to be detected as separate edges; shorter pulses or gaps are not guaranteed.

## Configuration
- AER_ARB_TIMEOUT_EN defined:
  - The watchdog counts cycles spent in REQ and RELEASE and resets on every state change.
  - At count = TIMEOUT_CYCLES: force aer_req=0, go to IDLE, pulse timeout_err, discard the current event, and leave the pointer advanced.
  - From RELEASE, the return to IDLE still requires synced ack = 0 before the next grant.
- AER_ARB_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely; timeout_err is tied to 0.

## Test plan
- Reset: hold reset=0 and toggle inputs → all outputs stay 0. Release reset, pulse Ch2Down_In → aer_req=1 with aer_addr=11 after 3 cycles; ack high→low → busy=0.
- Simultaneous Ch1Up_In and Ch2Up_In rising, with the receiver acking after 4 cycles → first grant addr=00, second grant addr=10, no event_drop.
- Fairness: all four lines pulsed repeatedly with the receiver continuously acking → grants cycle 00,01,10,11,00; no source is granted twice in a row while others are pending.
- Overflow: hold ack low, pulse Ch1Up_In three times → one grant in flight, one pending, one event_drop pulse; exactly two handshakes with addr=00 complete.
- Reset mid-handshake: assert reset while aer_req=1 → aer_req=0 within the same cycle; after release with no new events, busy stays 0.
- With AER_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, never ack → timeout_err pulses once 16 cycles after aer_req rises, and aer_req=0. Without the macro, aer_req stays 1 for 1000 cycles.
